// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: round-robin core/DMA data-memory sequencer; optional BUSY timeout under DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_mask,
  output logic        core_stall,
  output logic        core_done,
  output logic [31:0] core_rdata,
  output logic        core_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_mask,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        mem_cs_n,
  output logic        mem_we_n,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;
  logic gnt, last_grant, pick, pick_we, fin, to;
  // id 1 = DMA; on a tie the requester that did not win last time is picked
  assign pick = core_req & dma_req ? ~last_grant : dma_req;
  assign pick_we = pick ? dma_we : core_we;
  assign fin = mem_valid | to;
  assign core_stall = core_req & ~core_done;
`ifdef DMEM_TIMEOUT_EN
  logic [15:0] cnt;
  assign to = cnt == 16'(TIMEOUT_CYCLES);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= state == BUSY ? cnt + 16'd1 : '0;
`else
  logic unused_timeout;
  assign to = 1'b0;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      gnt <= 1'b0;
      last_grant <= 1'b1;
      mem_cs_n <= 1'b1;
      mem_we_n <= 1'b1;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_mask <= '0;
      core_done <= 1'b0;
      core_err <= 1'b0;
      core_rdata <= '0;
      dma_done <= 1'b0;
      dma_err <= 1'b0;
      dma_rdata <= '0;
    end else begin
      core_done <= 1'b0;
      dma_done <= 1'b0;
      core_err <= 1'b0;
      dma_err <= 1'b0;
      case (state)
        IDLE: if (core_req | dma_req) begin
          state <= BUSY;
          gnt <= pick;
          last_grant <= pick;
          mem_cs_n <= 1'b0;
          mem_we_n <= ~pick_we;
          mem_addr <= pick ? dma_addr : core_addr;
          mem_wdata <= pick ? dma_wdata : core_wdata;
          mem_mask <= pick_we ? (pick ? dma_mask : core_mask) : 4'hf;
        end
        BUSY: if (fin) begin
          state <= RESP;
          mem_cs_n <= 1'b1;
          if (gnt) begin
            dma_done <= 1'b1;
            dma_err <= ~mem_valid;
            if (mem_we_n) dma_rdata <= mem_valid ? mem_rdata : '0;
          end else begin
            core_done <= 1'b1;
            core_err <= ~mem_valid;
            if (mem_we_n) core_rdata <= mem_valid ? mem_rdata : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed checks of arbitration, handshake timing and reset for dmem_access_ctrl.
module tb_dmem_access_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic core_req = 0, core_we = 0, dma_req = 0, dma_we = 0, mem_valid = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
  logic [3:0] core_mask = 0, dma_mask = 0;
  logic core_stall, core_done, core_err, dma_done, dma_err, mem_cs_n, mem_we_n;
  logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_mask;
  int checks = 0, errors = 0;
  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_mask(core_mask), .core_stall(core_stall), .core_done(core_done), .core_rdata(core_rdata),
    .core_err(core_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_mask(dma_mask), .dma_done(dma_done), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    step;
    step;
    chk("rst_cs_n", mem_cs_n, 1);
    chk("rst_we_n", mem_we_n, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_mask", mem_mask, 0);
    chk("rst_done", {core_done, dma_done, core_err, dma_err}, 0);
    chk("rst_crdata", core_rdata, 0);
    chk("rst_drdata", dma_rdata, 0);
    rst = 0;
    // core load, valid two cycles after chip select
    core_req = 1; core_we = 0; core_addr = 32'h100;
    #1 chk("t1_stall_req", core_stall, 1);
    step;
    chk("t1_cs_n", mem_cs_n, 0);
    chk("t1_we_n", mem_we_n, 1);
    chk("t1_mask", mem_mask, 4'hf);
    chk("t1_addr", mem_addr, 32'h100);
    step;
    chk("t1_cs_n2", mem_cs_n, 0);
    step;
    mem_valid = 1; mem_rdata = 32'hDEADBEEF;
    chk("t1_done_early", core_done, 0);
    chk("t1_stall_busy", core_stall, 1);
    step;
    chk("t1_done", core_done, 1);
    chk("t1_rdata", core_rdata, 32'hDEADBEEF);
    chk("t1_stall_done", core_stall, 0);
    chk("t1_cs_n_resp", mem_cs_n, 1);
    chk("t1_err", core_err, 0);
    core_req = 0; mem_valid = 0;
    step;
    chk("t1_done_off", core_done, 0);
    chk("t1_cs_n_idle", mem_cs_n, 1);
    // core store, valid in the first chip-select cycle
    core_req = 1; core_we = 1; core_addr = 32'h204; core_wdata = 32'h0000AB00; core_mask = 4'b0010;
    step;
    chk("t2_we_n", mem_we_n, 0);
    chk("t2_mask", mem_mask, 4'b0010);
    chk("t2_wdata", mem_wdata, 32'h0000AB00);
    chk("t2_addr", mem_addr, 32'h204);
    mem_valid = 1; mem_rdata = 32'h11111111;
    step;
    chk("t2_done", core_done, 1);
    chk("t2_rdata_kept", core_rdata, 32'hDEADBEEF);
    core_req = 0; core_we = 0; mem_valid = 0;
    step;
    // both requesters held from reset: strict alternation
    rst = 1; core_req = 1; dma_req = 1; core_addr = 32'hC0; dma_addr = 32'hD0; dma_we = 0;
    step;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("t3_addr", mem_addr, i[0] ? 32'hD0 : 32'hC0);
      chk("t3_cs_n", mem_cs_n, 0);
      mem_valid = 1; mem_rdata = 32'h1000 + i;
      step;
      chk("t3_core_done", core_done, !i[0]);
      chk("t3_dma_done", dma_done, i[0]);
      chk("t3_rdata", i[0] ? dma_rdata : core_rdata, 32'h1000 + i);
      mem_valid = 0;
      step;
      chk("t3_idle_gap", mem_cs_n, 1);
    end
    // reset in BUSY after a core grant
    dma_req = 0;
    step;
    chk("t4_addr", mem_addr, 32'hC0);
    rst = 1;
    step;
    chk("t4_cs_n", mem_cs_n, 1);
    chk("t4_nodone", {core_done, dma_done}, 0);
    rst = 0; dma_req = 1;
    step;
    chk("t4_core_first", mem_addr, 32'hC0);
    chk("t4_nodone2", core_done, 0);
    mem_valid = 1; mem_rdata = 32'h55;
    step;
    chk("t4_done", core_done, 1);
    chk("t4_rdata", core_rdata, 32'h55);
    core_req = 0; dma_req = 0; mem_valid = 0;
    step;
    // dma drops its request mid-access while the core queues
    dma_req = 1; dma_addr = 32'hD0;
    step;
    dma_req = 0; core_req = 1; core_addr = 32'h300;
    #1 chk("t5_stall", core_stall, 1);
    step;
    chk("t5_cs_n", mem_cs_n, 0);
    chk("t5_addr_stable", mem_addr, 32'hD0);
    mem_valid = 1; mem_rdata = 32'hCAFEF00D;
    step;
    chk("t5_dma_done", dma_done, 1);
    chk("t5_dma_rdata", dma_rdata, 32'hCAFEF00D);
    chk("t5_core_done", core_done, 0);
    chk("t5_stall_wait", core_stall, 1);
    mem_valid = 0;
    step;
    chk("t5_idle", mem_cs_n, 1);
    step;
    chk("t5_core_addr", mem_addr, 32'h300);
    chk("t5_core_cs_n", mem_cs_n, 0);
    mem_valid = 1; mem_rdata = 32'h12345678;
    step;
    chk("t5_core_done2", core_done, 1);
    chk("t5_core_rdata", core_rdata, 32'h12345678);
    core_req = 0; mem_valid = 0;
    step;
    // stray valid outside BUSY is ignored
    mem_valid = 1;
    step;
    step;
    chk("t5_stray_done", {core_done, dma_done}, 0);
    chk("t5_stray_cs", mem_cs_n, 1);
    chk("t5_dma_err", dma_err, 0);
    mem_valid = 0;
`ifdef DMEM_TIMEOUT_EN
    core_req = 1; core_addr = 32'h400;
    step;
    for (int i = 1; i <= 4; i++) begin
      step;
      chk("t6_no_done", core_done, 0);
    end
    step;
    chk("t6_to_done", core_done, 1);
    chk("t6_to_err", core_err, 1);
    chk("t6_to_rdata", core_rdata, 0);
    core_req = 0;
    step;
    core_req = 1;
    step;
    for (int i = 1; i <= 4; i++) step;
    mem_valid = 1; mem_rdata = 32'h77;
    step;
    chk("t6_lim_done", core_done, 1);
    chk("t6_lim_err", core_err, 0);
    chk("t6_lim_rdata", core_rdata, 32'h77);
    core_req = 0; mem_valid = 0;
    step;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
